// File: rtl/img_pkg.sv
// Shared image-pipeline defaults, pixel type and an index-width helper
// for the window blocks.
package img_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 8;
    localparam int DEFAULT_IMAGE_WIDTH  = 640;
    localparam int DEFAULT_IMAGE_HEIGHT = 480;
    localparam int DEFAULT_WIN_SIZE     = 3;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] pixel_t;

    // Counters for a 1-deep dimension still need one bit to stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_mem.sv
// One stored image line: synchronous write, asynchronous read, shared address.
module line_mem
    import img_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_IMAGE_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_W     = idx_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; clearing every word would force flops
    // instead of RAM and nothing downstream relies on initial contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/line_buffer.sv
// Line buffer for a WIN_SIZE-high sliding window: stores WIN_SIZE-1 previous
// lines and presents the same-column pixels alongside the incoming pixel.
module line_buffer
    import img_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT,
    parameter int WIN_SIZE     = DEFAULT_WIN_SIZE
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  pixel_valid,
    input  logic [DATA_WIDTH-1:0]                 pixel_in,
    input  logic                                  sof,
    output logic [WIN_SIZE-2:0][DATA_WIDTH-1:0]   line_out,
    output logic [idx_width(IMAGE_WIDTH)-1:0]     col_idx,
    output logic [idx_width(IMAGE_HEIGHT)-1:0]    row_idx,
    output logic                                  rows_ready,
    output logic                                  frame_done
);

    localparam int COL_W = idx_width(IMAGE_WIDTH);
    localparam int ROW_W = idx_width(IMAGE_HEIGHT);

    localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_SOF   = (IMAGE_WIDTH == 1) ? '0 : COL_ONE;
    localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [ROW_W-1:0] READY_ROW = ROW_W'(WIN_SIZE - 1);

    logic             start;
    logic [COL_W-1:0] mem_addr;
    logic [COL_W-1:0] next_col;
    logic [ROW_W-1:0] next_row;
    logic             last_pixel;

    assign start = pixel_valid && sof;

    // A start-of-frame pixel lands in column 0 whatever col_idx says, so the
    // cascade reads and writes that column too.
    assign mem_addr = start ? '0 : col_idx;

    genvar k;
    generate
        for (k = 0; k < WIN_SIZE - 1; k++) begin : g_line
            logic [DATA_WIDTH-1:0] wdata;

            if (k == 0) begin : g_head
                assign wdata = pixel_in;
            end else begin : g_tail
                assign wdata = line_out[k-1];
            end

            line_mem #(
                .DEPTH      (IMAGE_WIDTH),
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_W     (COL_W)
            ) u_line_mem (
                .clk   (clk),
                .we    (pixel_valid),
                .addr  (mem_addr),
                .wdata (wdata),
                .rdata (line_out[k])
            );
        end
    endgenerate

    // NOTE: every output gets a default before any branch so the block
    // stays purely combinational and no latch is inferred.
    always_comb begin
        next_col   = col_idx + COL_ONE;
        next_row   = row_idx;
        last_pixel = 1'b0;
        if (sof) begin
            next_col = COL_SOF;
            next_row = '0;
        end else if (col_idx == COL_LAST) begin
            next_col   = '0;
            last_pixel = (row_idx == ROW_LAST);
            next_row   = last_pixel ? '0 : row_idx + ROW_ONE;
        end
    end

    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_idx    <= '0;
            row_idx    <= '0;
            rows_ready <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pixel_valid && last_pixel;
            if (pixel_valid) begin
                col_idx    <= next_col;
                row_idx    <= next_row;
                rows_ready <= (next_row >= READY_ROW);
            end
        end
    end

endmodule

// File: tb/tb_line_buffer.sv
// Self-checking bench for line_buffer (4x4 image, 3-line window) against a
// per-column write-history model.
module tb_line_buffer;

    localparam int DW = 8;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam int WS = 3;
    localparam int NPIX = IW * IH;
    localparam int HDEPTH = 64;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic                          pixel_valid;
    logic [DW-1:0]                 pixel_in;
    logic                          sof;
    logic [WS-2:0][DW-1:0]         line_out;
    logic [1:0]                    col_idx;
    logic [1:0]                    row_idx;
    logic                          rows_ready;
    logic                          frame_done;

    int n_checks = 0;
    int n_passed = 0;

    // Model: line_out[k] at column c is the (k+1)-th most recent value
    // written to column c; position is a linear pixel index within the frame.
    int hist [IW][HDEPTH];
    int cnt  [IW];
    int pos;
    bit exp_rr;
    bit exp_fd;

    line_buffer #(
        .DATA_WIDTH   (DW),
        .IMAGE_WIDTH  (IW),
        .IMAGE_HEIGHT (IH),
        .WIN_SIZE     (WS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pixel_valid (pixel_valid),
        .pixel_in    (pixel_in),
        .sof         (sof),
        .line_out    (line_out),
        .col_idx     (col_idx),
        .row_idx     (row_idx),
        .rows_ready  (rows_ready),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply inputs mid-cycle and compare everything visible before the edge.
    task automatic drive(input bit v, input bit s, input int p);
        int c;
        @(negedge clk);
        pixel_valid = v;
        sof         = s;
        pixel_in    = DW'(p);
        #1;
        check("col_idx", int'(col_idx), pos % IW);
        check("row_idx", int'(row_idx), pos / IW);
        check("rows_ready", int'(rows_ready), int'(exp_rr));
        check("frame_done", int'(frame_done), int'(exp_fd));
        if (v) begin
            c = s ? 0 : pos % IW;
            for (int k = 0; k < WS - 1; k++) begin
                if (cnt[c] > k) begin
                    check($sformatf("line_out[%0d]", k), int'(line_out[k]),
                          hist[c][(cnt[c] - 1 - k) % HDEPTH]);
                end
            end
        end
    endtask

    // Clock edge plus model update from the inputs that edge sampled.
    task automatic step();
        int c;
        @(posedge clk);
        if (!rst_n) begin
            pos    = 0;
            exp_rr = 1'b0;
            exp_fd = 1'b0;
        end else if (pixel_valid) begin
            c = sof ? 0 : pos % IW;
            hist[c][cnt[c] % HDEPTH] = int'(pixel_in);
            cnt[c]++;
            exp_fd = !sof && (pos == NPIX - 1);
            pos    = sof ? (1 % NPIX) : (pos + 1) % NPIX;
            exp_rr = (pos / IW) >= WS - 1;
        end else begin
            exp_fd = 1'b0;
        end
    endtask

    task automatic cycle(input bit v, input bit s, input int p);
        drive(v, s, p);
        step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        pixel_valid = 1'b0;
        sof         = 1'b0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        pixel_valid = 1'b0;
        sof         = 1'b0;
        pixel_in    = '0;
        pos         = 0;
        exp_rr      = 1'b0;
        exp_fd      = 1'b0;
        for (int c = 0; c < IW; c++) cnt[c] = 0;

        repeat (2) step();
        do_reset();
        drive(0, 0, 0);
        check("reset col_idx", int'(col_idx), 0);
        check("reset row_idx", int'(row_idx), 0);
        check("reset rows_ready", int'(rows_ready), 0);
        step();

        // Full-rate frame 0..15 with sof on the first pixel.
        for (int i = 0; i < NPIX; i++) begin
            drive(1, i == 0, i);
            if (i == 8) begin
                check("ready rises", int'(rows_ready), 1);
                check("ready col", int'(col_idx), 0);
                check("ready row", int'(row_idx), 2);
            end
            if (i == 9) begin
                check("px9 line_out[0]", int'(line_out[0]), 5);
                check("px9 line_out[1]", int'(line_out[1]), 1);
            end
            step();
        end
        drive(0, 0, 0);
        check("frame_done pulse", int'(frame_done), 1);
        check("wrap row", int'(row_idx), 0);
        check("wrap col", int'(col_idx), 0);
        step();
        drive(0, 0, 0);
        check("frame_done clears", int'(frame_done), 0);
        step();

        // Same frame with pixel_valid toggling.
        for (int i = 0; i < NPIX; i++) begin
            drive(1, i == 0, i);
            if (i == 9) begin
                check("gap px9 line_out[0]", int'(line_out[0]), 5);
                check("gap px9 line_out[1]", int'(line_out[1]), 1);
            end
            step();
            cycle(0, 0, 77);
        end
        cycle(0, 0, 0);

        // Restart mid-frame with sof carrying 100.
        for (int i = 0; i < 6; i++) cycle(1, i == 0, 200 + i);
        cycle(1, 1, 100);
        drive(0, 0, 0);
        check("sof col_idx", int'(col_idx), 1);
        check("sof row_idx", int'(row_idx), 0);
        check("sof rows_ready", int'(rows_ready), 0);
        step();
        for (int i = 1; i < IW; i++) cycle(1, 0, 110 + i);
        drive(1, 0, 120);
        check("col0 holds 100", int'(line_out[0]), 100);
        step();

        // Reset in the middle of a line.
        for (int i = 0; i < 7; i++) cycle(1, i == 0, 30 + i);
        do_reset();
        drive(0, 0, 0);
        check("midline rst col", int'(col_idx), 0);
        check("midline rst row", int'(row_idx), 0);
        check("midline rst ready", int'(rows_ready), 0);
        check("midline rst done", int'(frame_done), 0);
        step();

        // sof on the final pixel position suppresses frame_done.
        for (int i = 0; i < NPIX - 1; i++) cycle(1, i == 0, 50 + i);
        cycle(1, 1, 99);
        drive(0, 0, 0);
        check("sof@last no done", int'(frame_done), 0);
        check("sof@last col", int'(col_idx), 1);
        check("sof@last row", int'(row_idx), 0);
        step();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            bit v;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                v = ($urandom_range(0, 3) != 0);
                cycle(v, v && ($urandom_range(0, 40) == 0), int'($urandom_range(0, 255)));
            end
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
